// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the matrix storage reader (matrix_deconstruct) and
//   its read-return delay line (matrix_rd_pipe):
//     - default geometry (MAX_DIM_DEF, DATA_W_DEF)
//     - address / slot-index widths and types
//     - FSM state encoding
//     - tag carried alongside each outstanding read
//     - slot_index(): flattened row-major slot number of entry (row,col)
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int unsigned MAX_DIM_DEF = 128;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W      = 8;
  // Wide enough for 128*128-1 with headroom.
  localparam int unsigned SLOT_W      = 15;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Identity of one outstanding read; travels with the request until the
  // storage returns its data.
  typedef struct packed {
    logic  valid;
    addr_t row;
    addr_t col;
  } rd_tag_t;

  // Row-major slot number of (row,col) in a bus with 'dim' slots per row.
  function automatic slot_t slot_index(input addr_t row, input addr_t col,
                                       input int unsigned dim);
    return slot_t'(32'(row) * dim + 32'(col));
  endfunction

endpackage : matrix_pkg

// File: rtl/matrix_rd_pipe.sv
// ---------------------------------------------------------------------------
// matrix_rd_pipe
//   RD_LAT-deep delay line of read tags {valid,row,col}. A tag pushed on the
//   edge that ends a read-strobe cycle appears at tag_o exactly when the
//   storage presents the matching data, so the consumer captures rd_data on
//   the edge where tag_o.valid is high. Reset flushes every stage.
//
// Parameters
//   RD_LAT     storage read latency in cycles (1..4)
// Ports
//   clk        system clock
//   reset      synchronous active-high reset (flush)
//   tag_i      tag of the read issued this cycle (valid=0 when none)
//   tag_o      tag whose data is on rd_data this cycle
//   pending_o  a valid tag sits in a non-tail stage, i.e. the pipe will
//              still hold a read after the next edge
// ---------------------------------------------------------------------------
module matrix_rd_pipe
  import matrix_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    pending_o
);

  rd_tag_t stage_q [RD_LAT];

  // NOTE: clocked state is always written with non-blocking assignments so
  // every stage samples its neighbour's pre-edge value; blocking here would
  // collapse the shift register into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[RD_LAT-1];

  // The tail stage is excluded: it is consumed on the coming edge, so the
  // drain can finish one cycle earlier and done lands at m*n+RD_LAT+1.
  // NOTE: combinational outputs get a default before any conditional
  // update; without it a path that skips the assignment infers a latch.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      pending_o = pending_o | stage_q[i].valid;
    end
  end

endmodule : matrix_rd_pipe

// File: rtl/matrix_deconstruct.sv
// ---------------------------------------------------------------------------
// matrix_deconstruct
//   Reader side of the matrix storage interface. On an accepted start it
//   walks an m x n matrix row-major (column inner), one read strobe per
//   cycle, captures each entry RD_LAT cycles later and packs it into a flat
//   row-major bus: entry (i,j) at matrix_out[(i*MAX_DIM+j)*DATA_W +: DATA_W].
//   Slots outside the current m x n window keep their previous contents.
//   Invalid dimensions (0 or > MAX_DIM) finish immediately with err set and
//   no reads.
//
// Optional feature (compile-time macro MATRIX_DECONSTRUCT_TRANSPOSE_EN):
//   when defined, transpose is sampled at start and, if set, the entry read
//   at (i,j) is packed at slot (j,i); read order is unchanged. When not
//   defined the transpose input is ignored.
//
// Parameters
//   MAX_DIM    maximum rows/columns; slot stride per row of matrix_out
//   DATA_W     bits per matrix entry
//   RD_LAT     cycles from rd_en to valid rd_data (1..4)
// Ports
//   clk          system clock
//   reset        synchronous active-high reset; aborts a readout (no done)
//   start        single-cycle request, honoured only in IDLE
//   m_dim/n_dim  row/column count, sampled with start
//   transpose    pack transposed (optional feature only)
//   rd_en        read strobe to storage
//   m_addr       row address of the current read (holds when rd_en low)
//   n_addr       column address of the current read (holds when rd_en low)
//   rd_data      entry returned RD_LAT cycles after rd_en
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle pulse when matrix_out is complete
//   err          set with done for invalid dims; cleared by next start
//   matrix_out   flattened row-major matrix
// ---------------------------------------------------------------------------
module matrix_deconstruct
  import matrix_pkg::*;
#(
  parameter int unsigned MAX_DIM = MAX_DIM_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [7:0]                        m_dim,
  input  logic [7:0]                        n_dim,
  input  logic                              transpose,
  output logic                              rd_en,
  output logic [7:0]                        m_addr,
  output logic [7:0]                        n_addr,
  input  logic [DATA_W-1:0]                 rd_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_out
);

  localparam int unsigned       OUT_W     = MAX_DIM * MAX_DIM * DATA_W;
  // One extra bit so a limit of 128 compares cleanly against 8-bit dims.
  localparam logic [ADDR_W:0]   DIM_LIMIT = (ADDR_W + 1)'(MAX_DIM);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e  state_q, state_d;
  addr_t   m_q, m_d;
  addr_t   n_q, n_d;
  addr_t   m_addr_q, m_addr_d;
  addr_t   n_addr_q, n_addr_d;
  logic    err_q, err_d;

  logic [OUT_W-1:0] matrix_q;

  rd_tag_t issue_tag;
  rd_tag_t cap_tag;
  logic    pending;
  logic    dims_ok;
  logic    accept;
  logic    last_col;
  logic    last_row;
  slot_t   cap_slot;

  assign dims_ok = (m_dim != '0) && (n_dim != '0) &&
                   ({1'b0, m_dim} <= DIM_LIMIT) &&
                   ({1'b0, n_dim} <= DIM_LIMIT);

  assign accept   = (state_q == ST_IDLE) && start;
  assign last_col = (n_addr_q == n_q - addr_t'(1));
  assign last_row = (m_addr_q == m_q - addr_t'(1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    m_addr_d  = m_addr_q;
    n_addr_d  = n_addr_q;
    err_d     = err_q;
    issue_tag = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d = m_dim;
          n_d = n_dim;
          if (dims_ok) begin
            err_d    = 1'b0;
            m_addr_d = '0;
            n_addr_d = '0;
            state_d  = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end

      ST_ISSUE: begin
        issue_tag = '{valid: 1'b1, row: m_addr_q, col: n_addr_q};
        if (last_col) begin
          if (last_row) begin
            // Address stays on (m-1,n-1) while draining and in IDLE.
            state_d = ST_DRAIN;
          end else begin
            n_addr_d = '0;
            m_addr_d = m_addr_q + addr_t'(1);
          end
        end else begin
          n_addr_d = n_addr_q + addr_t'(1);
        end
      end

      ST_DRAIN: begin
        if (!pending) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      m_addr_q <= '0;
      n_addr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      m_addr_q <= m_addr_d;
      n_addr_q <= n_addr_d;
      err_q    <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read-return pipeline
  // -------------------------------------------------------------------------
  matrix_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_i     (issue_tag),
    .tag_o     (cap_tag),
    .pending_o (pending)
  );

  // -------------------------------------------------------------------------
  // Slot selection
  // -------------------------------------------------------------------------
`ifdef MATRIX_DECONSTRUCT_TRANSPOSE_EN
  logic tr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tr_q <= 1'b0;
    end else if (accept) begin
      tr_q <= transpose;
    end
  end

  // The pipe drains before done, so tr_q cannot change under an in-flight
  // read of the same readout.
  assign cap_slot = tr_q ? slot_index(cap_tag.col, cap_tag.row, MAX_DIM)
                         : slot_index(cap_tag.row, cap_tag.col, MAX_DIM);
`else
  logic unused_transpose;
  assign unused_transpose = transpose ^ accept;
  assign cap_slot         = slot_index(cap_tag.row, cap_tag.col, MAX_DIM);
`endif

  // -------------------------------------------------------------------------
  // Output matrix
  // -------------------------------------------------------------------------
  // NOTE: this wide array is cleared on reset because its zero state is an
  // architecturally visible output; plain storage arrays normally skip reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q <= '0;
    end else if (cap_tag.valid) begin
      matrix_q[int'(cap_slot) * DATA_W +: DATA_W] <= rd_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_en      = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign err        = err_q;
  assign m_addr     = m_addr_q;
  assign n_addr     = n_addr_q;
  assign matrix_out = matrix_q;

endmodule : matrix_deconstruct

// File: tb/tb_matrix_deconstruct.sv
// ---------------------------------------------------------------------------
// tb_matrix_deconstruct
//   Two instances: u_dut1 (MAX_DIM=128, RD_LAT=1) and u_dut3 (MAX_DIM=8,
//   RD_LAT=3), each fed by a storage model that answers a read at (r,c)
//   with {salt, r*mult+c} exactly RD_LAT cycles later (random data when no
//   read is due). Expected traces and matrices are derived from the
//   readout rules: row-major read list, done at m*n+RD_LAT+1, slot layout.
// ---------------------------------------------------------------------------
module tb_matrix_deconstruct;

  localparam int DW  = 32;
  localparam int MD1 = 128;
  localparam int MD3 = 8;
`ifdef MATRIX_DECONSTRUCT_TRANSPOSE_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic                  start1, tr1, rd_en1, busy1, done1, err1;
  logic [7:0]            m_dim1, n_dim1, m_addr1, n_addr1;
  logic [DW-1:0]         rd_data1;
  logic [MD1*MD1*DW-1:0] mo1;

  logic                  start3, tr3, rd_en3, busy3, done3, err3;
  logic [7:0]            m_dim3, n_dim3, m_addr3, n_addr3;
  logic [DW-1:0]         rd_data3;
  logic [MD3*MD3*DW-1:0] mo3;

  matrix_deconstruct #(.MAX_DIM(MD1), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .m_dim(m_dim1), .n_dim(n_dim1),
    .transpose(tr1), .rd_en(rd_en1), .m_addr(m_addr1), .n_addr(n_addr1),
    .rd_data(rd_data1), .busy(busy1), .done(done1), .err(err1),
    .matrix_out(mo1));

  matrix_deconstruct #(.MAX_DIM(MD3), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .m_dim(m_dim3), .n_dim(n_dim3),
    .transpose(tr3), .rd_en(rd_en3), .m_addr(m_addr3), .n_addr(n_addr3),
    .rd_data(rd_data3), .busy(busy3), .done(done3), .err(err3),
    .matrix_out(mo3));

  int checks = 0;
  int errors = 0;

  logic [15:0] salt = '0;
  int          mult = 16;

  function automatic logic [31:0] data_fn(input int r, input int c);
    return {salt, 16'(r * mult + c)};
  endfunction

  // ---------------- storage models ----------------
  typedef struct { bit en; int r; int c; } req_t;
  req_t q1[$];
  req_t q3[$];

  always @(negedge clk) begin
    req_t t;
    q1.push_back('{rd_en1 === 1'b1, int'(m_addr1), int'(n_addr1)});
    if (q1.size() > 1) begin
      t = q1.pop_front();
      rd_data1 = t.en ? data_fn(t.r, t.c) : 32'($urandom);
    end
  end

  always @(negedge clk) begin
    req_t t;
    q3.push_back('{rd_en3 === 1'b1, int'(m_addr3), int'(n_addr3)});
    if (q3.size() > 3) begin
      t = q3.pop_front();
      rd_data3 = t.en ? data_fn(t.r, t.c) : 32'($urandom);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp1 [MD1*MD1];
  logic [31:0] exp3 [MD3*MD3];
  int          last_r [2];
  int          last_c [2];

  function automatic int maxd_of(input int sel);
    return (sel == 0) ? MD1 : MD3;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] dut_slot(input int sel, input int idx);
    if (sel == 0) return mo1[idx*DW +: DW];
    return mo3[idx*DW +: DW];
  endfunction

  function automatic logic [31:0] get_exp(input int sel, input int idx);
    if (sel == 0) return exp1[idx];
    return exp3[idx];
  endfunction

  task automatic set_exp(input int sel, input int idx, input logic [31:0] v);
    if (sel == 0) exp1[idx] = v;
    else          exp3[idx] = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i < MD1*MD1; i++) exp1[i] = '0;
    for (int i = 0; i < MD3*MD3; i++) exp3[i] = '0;
    for (int s = 0; s < 2; s++) begin
      last_r[s] = 0;
      last_c[s] = 0;
    end
  endtask

  task automatic drive(input int sel, input bit st, input int m, input int n,
                       input bit tr);
    if (sel == 0) begin
      start1 = st; m_dim1 = 8'(m); n_dim1 = 8'(n); tr1 = tr;
    end else begin
      start3 = st; m_dim3 = 8'(m); n_dim3 = 8'(n); tr3 = tr;
    end
  endtask

  task automatic observe(input int sel, output logic en, output logic [7:0] r,
                         output logic [7:0] c, output logic bz,
                         output logic dn, output logic er);
    if (sel == 0) begin
      en = rd_en1; r = m_addr1; c = n_addr1; bz = busy1; dn = done1; er = err1;
    end else begin
      en = rd_en3; r = m_addr3; c = n_addr3; bz = busy3; dn = done3; er = err3;
    end
  endtask

  task automatic compare_matrix(input int sel, input string name);
    int bad;
    int first;
    int md;
    bad   = 0;
    first = 0;
    md    = maxd_of(sel);
    for (int i = 0; i < md*md; i++) begin
      if (dut_slot(sel, i) !== get_exp(sel, i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s matrix: %0d slots wrong, slot %0d got %h expected %h",
               name, bad, first, dut_slot(sel, first), get_exp(sel, first));
    end
  endtask

  task automatic check_slot(input int sel, input int r, input int c,
                            input logic [31:0] want, input string name);
    logic [31:0] got;
    got = dut_slot(sel, r * maxd_of(sel) + c);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s slot(%0d,%0d): got %h expected %h", name, r, c, got, want);
    end
  endtask

  task automatic check_reset_outputs(input int sel, input string name);
    logic en, bz, dn, er;
    logic [7:0] r, c;
    observe(sel, en, r, c, bz, dn, er);
    checks++;
    if ({en, bz, dn, er} !== 4'b0000 || r !== 8'd0 || c !== 8'd0) begin
      errors++;
      $display("FAIL %s outputs: rd_en %b busy %b done %b err %b addr (%0d,%0d), expected all zero",
               name, en, bz, dn, er, r, c);
    end
    compare_matrix(sel, name);
  endtask

  // One full readout: start in cycle 0, then every cycle through the IDLE
  // cycle after done is compared against the expected trace.
  task automatic run_job(input int sel, input int m, input int n, input bit tr,
                         input bit noisy, input string name);
    int    md, lat, mn, done_cyc, bad, er_row, er_col, slot;
    bit    ok, st, exp_en;
    logic  en, bz, dn, er;
    logic [7:0] r, c;
    string first;
    md       = maxd_of(sel);
    lat      = lat_of(sel);
    ok       = (m >= 1) && (m <= md) && (n >= 1) && (n <= md);
    mn       = ok ? m * n : 0;
    done_cyc = ok ? mn + lat + 1 : 1;
    bad      = 0;
    first    = "";
    if (ok) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          slot = (TR_EN && tr) ? j * md + i : i * md + j;
          set_exp(sel, slot, data_fn(i, j));
        end
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b1, m, n, tr);
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(posedge clk); #1;
      st = noisy && (cyc <= done_cyc) &&
           ((cyc == done_cyc) || ($urandom_range(0, 3) == 0));
      drive(sel, st, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom));
      @(negedge clk);
      observe(sel, en, r, c, bz, dn, er);
      exp_en = ok && (cyc <= mn);
      if (exp_en) begin
        er_row = (cyc - 1) / n;
        er_col = (cyc - 1) % n;
      end else if (ok) begin
        er_row = m - 1;
        er_col = n - 1;
      end else begin
        er_row = last_r[sel];
        er_col = last_c[sel];
      end
      if (en !== exp_en || r !== 8'(er_row) || c !== 8'(er_col) ||
          bz !== (cyc <= done_cyc) || dn !== (cyc == done_cyc) || er !== !ok) begin
        if (bad == 0)
          first = $sformatf("cyc %0d rd_en %b/%b addr (%0d,%0d)/(%0d,%0d) busy %b/%b done %b/%b err %b/%b",
                            cyc, en, exp_en, r, c, er_row, er_col, bz, (cyc <= done_cyc),
                            dn, (cyc == done_cyc), er, !ok);
        bad++;
      end
    end
    if (ok) begin
      last_r[sel] = m - 1;
      last_c[sel] = n - 1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s trace: %0d bad cycles, first got/expected %s", name, bad, first);
    end
    compare_matrix(sel, name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_model();
    check_reset_outputs(0, "reset_d1");
    check_reset_outputs(1, "reset_d3");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_small();
    salt = '0;
    mult = 16;
    run_job(0, 2, 3, 1'b0, 1'b0, "m2n3");
    check_slot(0, 1, 2, 32'h12, "m2n3");
    check_slot(0, 0, 1, 32'h01, "m2n3");
    run_job(0, 2, 3, 1'b1, 1'b0, "m2n3_tr");
    // Untransposed: (2,1) was never written and still holds reset zero.
    check_slot(0, 2, 1, TR_EN ? 32'h12 : 32'h00, "m2n3_tr");
    check_slot(0, 1, 0, TR_EN ? 32'h01 : 32'h10, "m2n3_tr");
  endtask

  task automatic test_single_lat3();
    salt = 16'($urandom);
    mult = 256;
    run_job(1, 1, 1, 1'b0, 1'b0, "m1n1_lat3");
    check_slot(1, 0, 0, data_fn(0, 0), "m1n1_lat3");
  endtask

  task automatic test_invalid();
    salt = 16'($urandom);
    run_job(0, 0, 3, 1'b0, 1'b0, "inv_m0");
    run_job(0, 2, 200, 1'b0, 1'b1, "inv_n200");
    run_job(1, 9, 1, 1'b0, 1'b0, "inv_m9_d3");
    run_job(1, 8, 0, 1'b1, 1'b0, "inv_n0_d3");
    run_job(1, 8, 8, 1'b1, 1'b1, "max_d3_after_err");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      salt = 16'($urandom);
      run_job(1, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              1'($urandom), 1'b1, $sformatf("rand_d3_%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      salt = 16'($urandom);
      run_job(0, int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              1'($urandom), 1'b1, $sformatf("rand_d1_%0d", k));
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    salt = 16'($urandom);
    mult = 256;
    @(posedge clk); #1;
    drive(0, 1'b1, 4, 4, 1'b0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 4, 4, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    clear_model();
    check_reset_outputs(0, "reset_mid_d1");
    check_reset_outputs(1, "reset_mid_d3");
    stray = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || rd_en1 !== 1'b0 || busy1 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid idle: %0d cycles with done/rd_en/busy after abort, expected 0", stray);
    end
    run_job(0, 2, 2, 1'b0, 1'b0, "after_abort_m2n2");
  endtask

  task automatic test_full();
    salt = 16'($urandom);
    mult = 256;
    run_job(0, 128, 128, 1'($urandom), 1'b1, "full128");
    check_slot(0, 127, 127, data_fn(127, 127), "full128");
    checks++;
    if (mo1[MD1*MD1*DW-1 -: DW] !== data_fn(127, 127)) begin
      errors++;
      $display("FAIL full128 top word: got %h expected %h",
               mo1[MD1*MD1*DW-1 -: DW], data_fn(127, 127));
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_single_lat3();
    test_invalid();
    test_random();
    test_reset_mid();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_matrix_deconstruct
